// File: rtl/router_xbar.sv
// router_xbar: NUM_PORTS x NUM_PORTS flit crossbar. Each input buffers flits in
// its own FIFO; each output has a round-robin arbiter over the FIFO heads and
// a registered output stage. Flits with an out-of-range destination are
// counted and discarded at the input.
module router_xbar #(
    parameter int NUM_PORTS  = 4,
    parameter int DATA_W     = 32,
    parameter int DEST_W     = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_PORTS-1:0]          in_valid,
    output logic [NUM_PORTS-1:0]          in_ready,
    input  logic [NUM_PORTS*DEST_W-1:0]   in_dest,
    input  logic [NUM_PORTS*DATA_W-1:0]   in_data,
    output logic [NUM_PORTS-1:0]          out_valid,
    input  logic [NUM_PORTS-1:0]          out_ready,
    output logic [NUM_PORTS*DATA_W-1:0]   out_data,
    output logic [NUM_PORTS*DEST_W-1:0]   out_src,
    output logic [15:0]                   drop_cnt
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W-1:0]    r_fifo_data [NUM_PORTS][FIFO_DEPTH];
    logic [DEST_W-1:0]    r_fifo_dest [NUM_PORTS][FIFO_DEPTH];
    logic [AW-1:0]        r_wr_ptr    [NUM_PORTS];
    logic [AW-1:0]        r_rd_ptr    [NUM_PORTS];
    logic [CW-1:0]        r_count     [NUM_PORTS];
    logic [DEST_W-1:0]    r_arb_ptr   [NUM_PORTS];
    logic [NUM_PORTS-1:0] r_out_valid;
    logic [DATA_W-1:0]    r_out_data  [NUM_PORTS];
    logic [DEST_W-1:0]    r_out_src   [NUM_PORTS];
    logic [15:0]          r_drop_cnt;

    logic [NUM_PORTS-1:0] w_full;
    logic [NUM_PORTS-1:0] w_empty;
    logic [NUM_PORTS-1:0] w_push;
    logic [NUM_PORTS-1:0] w_pop;
    logic [DEST_W-1:0]    w_head_dest [NUM_PORTS];
    logic [DATA_W-1:0]    w_head_data [NUM_PORTS];
    logic [NUM_PORTS-1:0] w_grant_vld;
    logic [DEST_W-1:0]    w_grant_idx [NUM_PORTS];
    logic [15:0]          w_drop_inc;
    logic [16:0]          w_drop_next;
    logic [DEST_W-1:0]    w_cand;
    int                   w_sum;

    // FIFO occupancy flags and head-of-queue view
    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            w_full[i]      = (r_count[i] == CW'(FIFO_DEPTH));
            w_empty[i]     = (r_count[i] == '0);
            w_head_dest[i] = r_fifo_dest[i][r_rd_ptr[i]];
            w_head_data[i] = r_fifo_data[i][r_rd_ptr[i]];
        end
    end

    // Ready depends only on registered occupancy, never on valid/ready inputs
    assign in_ready = ~w_full & {NUM_PORTS{rst_n}};

    // Split accepted flits into FIFO writes and illegal-destination drops
    always_comb begin
        w_push     = '0;
        w_drop_inc = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (in_valid[i] && in_ready[i]) begin
                if (32'(in_dest[i*DEST_W +: DEST_W]) < NUM_PORTS) begin
                    w_push[i] = 1'b1;
                end else begin
                    w_drop_inc = w_drop_inc + 16'd1;
                end
            end
        end
    end

    // Per-output round-robin search from r_arb_ptr upward; a head requests
    // only its own destination, so an input wins at most one output
    always_comb begin
        w_pop  = '0;
        w_cand = '0;
        w_sum  = 0;
        for (int j = 0; j < NUM_PORTS; j++) begin
            w_grant_vld[j] = 1'b0;
            w_grant_idx[j] = '0;
            if (!r_out_valid[j] || out_ready[j]) begin
                for (int o = 0; o < NUM_PORTS; o++) begin
                    w_sum = 32'(r_arb_ptr[j]) + o;
                    if (w_sum >= NUM_PORTS) begin
                        w_sum = w_sum - NUM_PORTS;
                    end
                    w_cand = DEST_W'(w_sum);
                    if (!w_grant_vld[j] && !w_empty[w_cand] &&
                        (w_head_dest[w_cand] == DEST_W'(j))) begin
                        w_grant_vld[j] = 1'b1;
                        w_grant_idx[j] = w_cand;
                        w_pop[w_cand]  = 1'b1;
                    end
                end
            end
        end
    end

    // FIFO storage; contents need no reset because occupancy gates every read
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (w_push[i]) begin
                r_fifo_data[i][r_wr_ptr[i]] <= in_data[i*DATA_W +: DATA_W];
                r_fifo_dest[i][r_wr_ptr[i]] <= in_dest[i*DEST_W +: DEST_W];
            end
        end
    end

    // FIFO pointers and occupancy; simultaneous push and pop leave count unchanged
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                r_wr_ptr[i] <= '0;
                r_rd_ptr[i] <= '0;
                r_count[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (w_push[i]) begin
                    r_wr_ptr[i] <= r_wr_ptr[i] + 1'b1;
                end
                if (w_pop[i]) begin
                    r_rd_ptr[i] <= r_rd_ptr[i] + 1'b1;
                end
                case ({w_push[i], w_pop[i]})
                    2'b10:   r_count[i] <= r_count[i] + 1'b1;
                    2'b01:   r_count[i] <= r_count[i] - 1'b1;
                    default: r_count[i] <= r_count[i];
                endcase
            end
        end
    end

    // Output registers: load on grant, clear valid when drained, hold when stalled
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_valid <= '0;
            for (int j = 0; j < NUM_PORTS; j++) begin
                r_out_data[j] <= '0;
                r_out_src[j]  <= '0;
                r_arb_ptr[j]  <= '0;
            end
        end else begin
            for (int j = 0; j < NUM_PORTS; j++) begin
                if (w_grant_vld[j]) begin
                    r_out_valid[j] <= 1'b1;
                    r_out_data[j]  <= w_head_data[w_grant_idx[j]];
                    r_out_src[j]   <= w_grant_idx[j];
                    r_arb_ptr[j]   <= (32'(w_grant_idx[j]) == NUM_PORTS - 1) ?
                                      '0 : w_grant_idx[j] + 1'b1;
                end else if (out_ready[j]) begin
                    r_out_valid[j] <= 1'b0;
                end
            end
        end
    end

    assign w_drop_next = {1'b0, r_drop_cnt} + {1'b0, w_drop_inc};

    // Saturating count of flits discarded for an illegal destination
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_drop_cnt <= '0;
        end else if (w_drop_next[16]) begin
            r_drop_cnt <= 16'hFFFF;
        end else begin
            r_drop_cnt <= w_drop_next[15:0];
        end
    end

    // Pack per-output registers onto the flat output buses
    always_comb begin
        for (int j = 0; j < NUM_PORTS; j++) begin
            out_data[j*DATA_W +: DATA_W] = r_out_data[j];
            out_src[j*DEST_W +: DEST_W]  = r_out_src[j];
        end
    end

    assign out_valid = r_out_valid;
    assign drop_cnt  = r_drop_cnt;

endmodule

// File: tb/tb_router_xbar.sv
// tb_router_xbar: directed bench for router_xbar with a per-output scoreboard.
// Instance A is the default 4-port crossbar; instance B has 3 ports with a
// 2-bit destination so that destination 3 is illegal.
module tb_router_xbar;
    localparam int NP = 4;
    localparam int NB = 3;
    localparam int DW = 32;
    localparam int SW = 2;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [NP-1:0]    a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [NP*SW-1:0] a_in_dest, a_out_src;
    logic [NP*DW-1:0] a_in_data, a_out_data;
    logic [15:0]      a_drop_cnt;

    logic [NB-1:0]    b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [NB*SW-1:0] b_in_dest, b_out_src;
    logic [NB*DW-1:0] b_in_data, b_out_data;
    logic [15:0]      b_drop_cnt;

    router_xbar #(.NUM_PORTS(NP), .DATA_W(DW), .DEST_W(SW), .FIFO_DEPTH(4)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_dest(a_in_dest), .in_data(a_in_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .out_src(a_out_src), .drop_cnt(a_drop_cnt)
    );

    router_xbar #(.NUM_PORTS(NB), .DATA_W(DW), .DEST_W(SW), .FIFO_DEPTH(4)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_dest(b_in_dest), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .out_src(b_out_src), .drop_cnt(b_drop_cnt)
    );

    typedef struct packed {
        logic [DW-1:0] data;
        logic [SW-1:0] src;
    } exp_t;

    exp_t sbq [NP][$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input int p, input logic v, input logic [SW-1:0] d, input logic [DW-1:0] x);
        a_in_valid[p]          = v;
        a_in_dest[p*SW +: SW]  = d;
        a_in_data[p*DW +: DW]  = x;
    endtask

    task automatic drive_b(input int p, input logic v, input logic [SW-1:0] d, input logic [DW-1:0] x);
        b_in_valid[p]          = v;
        b_in_dest[p*SW +: SW]  = d;
        b_in_data[p*DW +: DW]  = x;
    endtask

    task automatic drain(input int o);
        for (int c = 0; c < 32 && sbq[o].size() != 0; c++) step();
        chk("drain_empty", 64'(sbq[o].size()), 64'd0);
    endtask

    // Scoreboard: every output transfer of instance A must match the next expected flit
    always @(negedge clk) begin
        for (int j = 0; j < NP; j++) begin
            if (rst_n === 1'b1 && a_out_valid[j] === 1'b1 && a_out_ready[j] === 1'b1) begin
                chk("expected_flit_present", 64'(sbq[j].size() != 0), 64'd1);
                if (sbq[j].size() != 0) begin
                    mon_e = sbq[j].pop_front();
                    chk("out_flit", 64'({a_out_data[j*DW +: DW], a_out_src[j*SW +: SW]}), 64'(mon_e));
                end
            end
        end
    end

    int   sent;
    int   hi;
    int   rises;
    logic prev;

    task automatic track1();
        if (a_out_valid[1]) hi++;
        if (a_out_valid[1] && !prev) rises++;
        prev = a_out_valid[1];
    endtask

    initial begin
        rst_n = 1'b0;
        a_in_valid = '0; a_in_dest = '0; a_in_data = '0; a_out_ready = '0;
        b_in_valid = '0; b_in_dest = '0; b_in_data = '0; b_out_ready = '0;
        step(); step();
        chk("rst_out_valid", 64'(a_out_valid), 64'd0);
        chk("rst_in_ready", 64'(a_in_ready), 64'd0);
        chk("rst_out_data", 64'(a_out_data[63:0]), 64'd0);
        chk("rst_drop_cnt_b", 64'(b_drop_cnt), 64'd0);
        rst_n = 1'b1;
        #1;
        chk("rel_in_ready", 64'(a_in_ready), 64'hF);

        // Single flit: port 0 -> output 2, visible two cycles after in_valid
        a_out_ready = '1;
        drive_a(0, 1'b1, 2'd2, 32'hA5A5_0001);
        sbq[2].push_back(exp_t'({32'hA5A5_0001, 2'd0}));
        step();
        drive_a(0, 1'b0, 2'd0, 32'h0);
        chk("single_not_early", 64'(a_out_valid[2]), 64'd0);
        step();
        chk("single_valid", 64'(a_out_valid), 64'h4);
        chk("single_data", 64'(a_out_data[2*DW +: DW]), 64'hA5A5_0001);
        chk("single_src", 64'(a_out_src[2*SW +: SW]), 64'd0);
        step();

        // Contention: ports 0,1,3 each send 4 flits to output 1
        hi = 0; rises = 0; prev = 1'b0;
        for (int n = 0; n < 4; n++) begin
            chk("cont_in_ready", 64'(a_in_ready & 4'b1011), 64'h0B);
            drive_a(0, 1'b1, 2'd1, 32'hC000_0000 + 32'(n));
            drive_a(1, 1'b1, 2'd1, 32'hC000_0010 + 32'(n));
            drive_a(3, 1'b1, 2'd1, 32'hC000_0030 + 32'(n));
            sbq[1].push_back(exp_t'({32'hC000_0000 + 32'(n), 2'd0}));
            sbq[1].push_back(exp_t'({32'hC000_0010 + 32'(n), 2'd1}));
            sbq[1].push_back(exp_t'({32'hC000_0030 + 32'(n), 2'd3}));
            step();
            track1();
        end
        a_in_valid = '0;
        for (int c = 0; c < 16; c++) begin
            step();
            track1();
        end
        chk("cont_flit_cycles", 64'(hi), 64'd12);
        chk("cont_back_to_back", 64'(rises), 64'd1);
        chk("cont_all_out", 64'(sbq[1].size()), 64'd0);

        // Backpressure: output 0 stalled while port 2 streams into it
        a_out_ready = 4'b1110;
        sent = 0;
        for (int c = 0; c < 10; c++) begin
            drive_a(2, 1'b1, 2'd0, 32'hB000_0000 + 32'(sent));
            if (a_in_ready[2]) begin
                sbq[0].push_back(exp_t'({32'hB000_0000 + 32'(sent), 2'd2}));
                sent++;
            end
            step();
            if (c >= 1) begin
                chk("bp_hold_valid", 64'(a_out_valid[0]), 64'd1);
                chk("bp_hold_data", 64'(a_out_data[DW-1:0]), 64'hB000_0000);
            end
        end
        chk("bp_accepted", 64'(sent), 64'd5);
        chk("bp_in_ready_low", 64'(a_in_ready[2]), 64'd0);
        a_out_ready[0] = 1'b1;
        for (int c = 0; c < 40 && sent < 12; c++) begin
            drive_a(2, 1'b1, 2'd0, 32'hB000_0000 + 32'(sent));
            if (a_in_ready[2]) begin
                sbq[0].push_back(exp_t'({32'hB000_0000 + 32'(sent), 2'd2}));
                sent++;
            end
            step();
        end
        drive_a(2, 1'b0, 2'd0, 32'h0);
        chk("bp_sent_all", 64'(sent), 64'd12);
        drain(0);

        // Independent outputs: every input to a different output at once
        a_out_ready = '1;
        for (int n = 0; n < 3; n++) begin
            chk("ind_in_ready", 64'(a_in_ready), 64'hF);
            for (int p = 0; p < NP; p++) begin
                drive_a(p, 1'b1, SW'((p + 2) % NP), 32'hD000_0000 + 32'(p * 16 + n));
                sbq[(p + 2) % NP].push_back(exp_t'({32'hD000_0000 + 32'(p * 16 + n), SW'(p)}));
            end
            step();
            if (n == 1) chk("ind_all_valid", 64'(a_out_valid), 64'hF);
        end
        a_in_valid = '0;
        for (int o = 0; o < NP; o++) drain(o);

        // Illegal destination on the 3-port instance
        b_out_ready = '1;
        drive_b(1, 1'b1, 2'd3, 32'hDEAD_0000);
        for (int n = 0; n < 5; n++) begin
            step();
            chk("ill_no_out", 64'(b_out_valid), 64'd0);
        end
        drive_b(1, 1'b0, 2'd0, 32'h0);
        chk("ill_drop5", 64'(b_drop_cnt), 64'd5);
        drive_b(1, 1'b1, 2'd0, 32'hC0DE_0001);
        step();
        drive_b(1, 1'b0, 2'd0, 32'h0);
        chk("ill_legal_not_early", 64'(b_out_valid), 64'd0);
        step();
        chk("ill_legal_valid", 64'(b_out_valid), 64'h1);
        chk("ill_legal_data", 64'(b_out_data[DW-1:0]), 64'hC0DE_0001);
        chk("ill_legal_src", 64'(b_out_src[SW-1:0]), 64'd1);
        step();
        drive_b(0, 1'b1, 2'd3, 32'h1);
        drive_b(2, 1'b1, 2'd3, 32'h2);
        step();
        chk("ill_two_same_cycle", 64'(b_drop_cnt), 64'd7);
        drive_b(1, 1'b1, 2'd3, 32'h3);
        for (int c = 0; c < 21842; c++) step();
        b_in_valid = '0;
        chk("sat_fill", 64'(b_drop_cnt), 64'hFFFD);
        chk("sat_in_ready", 64'(b_in_ready), 64'h7);
        b_in_valid = 3'b001;
        step();
        chk("sat_fffe", 64'(b_drop_cnt), 64'hFFFE);
        b_in_valid = 3'b111;
        step();
        chk("sat_clamp", 64'(b_drop_cnt), 64'hFFFF);
        step();
        b_in_valid = '0;
        chk("sat_hold", 64'(b_drop_cnt), 64'hFFFF);

        // Reset mid-traffic with every FIFO full and every output stalled
        a_out_ready = '0;
        for (int n = 0; n < 5; n++) begin
            for (int p = 0; p < NP; p++)
                drive_a(p, 1'b1, SW'((p + 1) % NP), 32'hE000_0000 + 32'(p * 16 + n));
            step();
        end
        a_in_valid = '0;
        chk("mid_full", 64'(a_in_ready), 64'd0);
        chk("mid_valid", 64'(a_out_valid), 64'hF);
        rst_n = 1'b0;
        step();
        chk("mid_rst_valid", 64'(a_out_valid), 64'd0);
        chk("mid_rst_in_ready", 64'(a_in_ready), 64'd0);
        chk("mid_rst_data", 64'(a_out_data[127:64]), 64'd0);
        chk("mid_rst_src", 64'(a_out_src), 64'd0);
        chk("mid_rst_drop_b", 64'(b_drop_cnt), 64'd0);
        rst_n = 1'b1;
        #1;
        chk("mid_rel_in_ready", 64'(a_in_ready), 64'hF);
        a_out_ready = '1;
        for (int c = 0; c < 6; c++) begin
            step();
            chk("mid_no_emit", 64'(a_out_valid), 64'd0);
        end

        for (int o = 0; o < NP; o++) chk("final_queue_empty", 64'(sbq[o].size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
